// File: rtl/mpsk_mod_if.sv
// Serial bit intake handshake for mpsk_mod: the source drives bit_in/bit_valid,
// the modulator answers with bit_ready.
interface mpsk_mod_if;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;

    modport master (output bit_in, output bit_valid, input bit_ready);
    modport slave  (input bit_in, input bit_valid, output bit_ready);
endinterface

// File: rtl/mpsk_mod.sv
// M-ary PSK modulator: serial bits -> symbols -> phase-offset DDS sine, offset-binary out.
// Define MPSK_DIFF_EN for differential PSK (phase accumulates per symbol).
module mpsk_mod #(
    parameter int unsigned DATA_W       = 10,
    parameter int unsigned PHASE_W      = 32,
    parameter int unsigned LUT_AW       = 10,
    parameter int unsigned BITS_PER_SYM = 1,
    parameter int unsigned SYM_CYC      = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] fword,
    mpsk_mod_if.slave          bit_if,
    output logic [DATA_W-1:0]  sin_out,
    output logic               out_valid,
    output logic               sym_strobe,
    output logic               underrun
);
    localparam int unsigned M     = 2 ** BITS_PER_SYM;
    localparam int unsigned CNT_W = (SYM_CYC > 1) ? $clog2(SYM_CYC) : 1;
    localparam int unsigned BC_W  = (BITS_PER_SYM > 1) ? $clog2(BITS_PER_SYM) : 1;
    localparam logic [BITS_PER_SYM-1:0] HALF = BITS_PER_SYM'(M / 2);
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W - 1){1'b0}}};

    function automatic logic [DATA_W-1:0] rom_val(input int unsigned k);
        real amp;
        real v;
        int  r;
        amp = real'(2 ** (DATA_W - 1) - 1);
        v   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(2 ** LUT_AW));
        r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return DATA_W'(2 ** (DATA_W - 1) + r);
    endfunction

    logic [DATA_W-1:0] rom [2**LUT_AW];
    for (genvar k = 0; k < 2 ** LUT_AW; k++) begin : g_rom
        assign rom[k] = rom_val(k);
    end

    logic [PHASE_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic [BC_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_SYM-1:0] asm_q, asm_d;
    logic [BITS_PER_SYM-1:0] pend_q, pend_d;
    logic [BITS_PER_SYM-1:0] cur_sym_q, cur_sym_d;
    logic                    pend_full_q, pend_full_d;
    logic                    strobe_q, strobe_d;
    logic                    underrun_q, underrun_d;
    logic [LUT_AW-1:0]       addr_q, addr_d;
    logic                    v1_q, valid_q;
    logic [DATA_W-1:0]       sin_q;

    logic                    accept, last_bit, boundary;
    logic [BITS_PER_SYM-1:0] shifted, phase_sel;
    logic [LUT_AW-1:0]       offset;

`ifdef MPSK_DIFF_EN
    logic [BITS_PER_SYM-1:0] ph_q, ph_d;
    assign phase_sel = ph_q;
`else
    assign phase_sel = cur_sym_q + HALF;
`endif

    assign offset = LUT_AW'(phase_sel) << (LUT_AW - BITS_PER_SYM);

    always_comb begin
        accept      = bit_if.bit_valid && !pend_full_q && en;
        last_bit    = (bit_cnt_q == BC_W'(BITS_PER_SYM - 1));
        boundary    = en && (sym_cnt_q == CNT_W'(SYM_CYC - 1));
        shifted     = BITS_PER_SYM'({asm_q, bit_if.bit_in});
        acc_d       = acc_q;
        sym_cnt_d   = sym_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        asm_d       = asm_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cur_sym_d   = cur_sym_q;
        strobe_d    = 1'b0;
        underrun_d  = 1'b0;
        addr_d      = acc_q[PHASE_W-1 -: LUT_AW] + offset;
`ifdef MPSK_DIFF_EN
        ph_d        = ph_q;
`endif
        if (en) begin
            acc_d     = acc_q + fword;
            sym_cnt_d = boundary ? '0 : sym_cnt_q + CNT_W'(1);
        end
        if (accept) begin
            asm_d = shifted;
            if (last_bit) begin
                pend_d      = shifted;
                pend_full_d = 1'b1;
                bit_cnt_d   = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
        end
        // The boundary looks only at the registered pend_full, so a symbol
        // completing in the same cycle waits for the next boundary.
        if (boundary) begin
            if (pend_full_q) begin
                cur_sym_d   = pend_q;
                pend_full_d = 1'b0;
                strobe_d    = 1'b1;
`ifdef MPSK_DIFF_EN
                ph_d        = ph_q + pend_q + HALF;
`endif
            end else begin
                cur_sym_d  = '0;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            sym_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            asm_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cur_sym_q   <= '0;
            strobe_q    <= 1'b0;
            underrun_q  <= 1'b0;
            addr_q      <= '0;
            v1_q        <= 1'b0;
            valid_q     <= 1'b0;
            sin_q       <= MID;
`ifdef MPSK_DIFF_EN
            ph_q        <= '0;
`endif
        end else begin
            acc_q       <= acc_d;
            sym_cnt_q   <= sym_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            asm_q       <= asm_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            cur_sym_q   <= cur_sym_d;
            strobe_q    <= strobe_d;
            underrun_q  <= underrun_d;
            addr_q      <= addr_d;
            v1_q        <= en;
            valid_q     <= v1_q;
            if (v1_q) sin_q <= rom[addr_q];
`ifdef MPSK_DIFF_EN
            ph_q        <= ph_d;
`endif
        end
    end

    assign bit_if.bit_ready = !pend_full_q;
    assign sin_out          = sin_q;
    assign out_valid        = valid_q;
    assign sym_strobe       = strobe_q;
    assign underrun         = underrun_q;
endmodule

// File: tb/tb_mpsk_mod.sv
// Directed bench for mpsk_mod: a BPSK and a QPSK instance (SYM_CYC=16, 16 samples/period).
module tb_mpsk_mod;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] fword = 32'h1000_0000;
    logic [9:0]  b_sin, q_sin;
    logic        b_vld, b_stb, b_und, q_vld, q_stb, q_und;
    int          vec = 0;
    int          errs = 0;
    bit          qb[$];
    bit          qq[$];

    // ROM[64*i] for i = 0..15
    logic [9:0] rom64 [16] = '{512, 708, 873, 984, 1023, 984, 873, 708,
                               512, 316, 151, 40, 1, 40, 151, 316};
`ifdef MPSK_DIFF_EN
    localparam int DIFF = 1;
    localparam int UND_OFF = 0;
    logic [9:0] q_e0 [4] = '{512, 1023, 1, 512};
    logic [9:0] q_e1 [4] = '{708, 984, 40, 316};
`else
    localparam int DIFF = 0;
    localparam int UND_OFF = 8;
    logic [9:0] q_e0 [4] = '{512, 1023, 512, 1};
    logic [9:0] q_e1 [4] = '{708, 984, 316, 40};
`endif

    mpsk_mod_if ifb();
    mpsk_mod_if ifq();

    mpsk_mod #(.DATA_W(10), .PHASE_W(32), .LUT_AW(10), .BITS_PER_SYM(1), .SYM_CYC(16)) u_bpsk (
        .clk(clk), .rst_n(rst_n), .en(en), .fword(fword), .bit_if(ifb),
        .sin_out(b_sin), .out_valid(b_vld), .sym_strobe(b_stb), .underrun(b_und));

    mpsk_mod #(.DATA_W(10), .PHASE_W(32), .LUT_AW(10), .BITS_PER_SYM(2), .SYM_CYC(16)) u_qpsk (
        .clk(clk), .rst_n(rst_n), .en(en), .fword(fword), .bit_if(ifq),
        .sin_out(q_sin), .out_valid(q_vld), .sym_strobe(q_stb), .underrun(q_und));

    always #5 clk = ~clk;

    task automatic start();
        rst_n = 1'b0;
        en = 1'b0;
        qb.delete();
        qq.delete();
        ifb.bit_valid = 1'b0; ifb.bit_in = 1'b0;
        ifq.bit_valid = 1'b0; ifq.bit_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives the head of each bit queue; pops it when it will be accepted this cycle.
    task automatic feed();
        ifb.bit_valid = (qb.size() > 0);
        ifb.bit_in    = (qb.size() > 0) ? qb[0] : 1'b0;
        if (qb.size() > 0 && ifb.bit_ready && en) void'(qb.pop_front());
        ifq.bit_valid = (qq.size() > 0);
        ifq.bit_in    = (qq.size() > 0) ? qq[0] : 1'b0;
        if (qq.size() > 0 && ifq.bit_ready && en) void'(qq.pop_front());
    endtask

    task automatic test_reset();
        int bs = 0;
        int qs = 0;
        start();
        qb.push_back(1'b1);
        qq.push_back(1'b1);
        for (int c = 0; c < 6; c++) begin en = 1'b1; feed(); @(negedge clk); end
        #2 rst_n = 1'b0;
        #1;
        vec++; if (b_sin !== 10'd512) begin errs++; $display("FAIL reset_b_sin: got %0d want 512", b_sin); end
        vec++; if (b_vld !== 1'b0) begin errs++; $display("FAIL reset_b_valid: got %b want 0", b_vld); end
        vec++; if (ifb.bit_ready !== 1'b1) begin errs++; $display("FAIL reset_b_ready: got %b want 1", ifb.bit_ready); end
        vec++; if (q_sin !== 10'd512) begin errs++; $display("FAIL reset_q_sin: got %0d want 512", q_sin); end
        vec++; if (q_vld !== 1'b0) begin errs++; $display("FAIL reset_q_valid: got %b want 0", q_vld); end
        vec++; if (ifq.bit_ready !== 1'b1) begin errs++; $display("FAIL reset_q_ready: got %b want 1", ifq.bit_ready); end
        start();
        qq.push_back(1'b1);
        for (int c = 0; c < 34; c++) begin
            if (c == 17) qq.push_back(1'b0);
            if (b_stb) bs++;
            if (q_stb) qs++;
            if (c == 16) begin
                vec++; if (b_und !== 1'b1) begin errs++; $display("FAIL reset_b_discard: underrun=%b want 1", b_und); end
                vec++; if (q_und !== 1'b1) begin errs++; $display("FAIL reset_q_partial: underrun=%b want 1", q_und); end
            end
            if (c == 32) begin
                vec++; if (q_stb !== 1'b1) begin errs++; $display("FAIL reset_q_full_sym: strobe=%b want 1", q_stb); end
            end
            en = 1'b1; feed(); @(negedge clk);
        end
        vec++; if (bs != 0) begin errs++; $display("FAIL reset_b_strobes: got %0d want 0", bs); end
        vec++; if (qs != 1) begin errs++; $display("FAIL reset_q_strobes: got %0d want 1", qs); end
    endtask

    task automatic test_bpsk();
        start();
        qb.push_back(1'b1);
        qb.push_back(1'b0);
        for (int c = 0; c < 50; c++) begin
            if (c == 1) begin
                vec++; if (b_vld !== 1'b0) begin errs++; $display("FAIL bpsk_valid_lat1: got %b want 0", b_vld); end
            end
            if (c == 2) begin
                vec++; if (b_vld !== 1'b1) begin errs++; $display("FAIL bpsk_valid_lat2: got %b want 1", b_vld); end
            end
            if (c == 16 || c == 32) begin
                vec++; if (b_stb !== 1'b1) begin errs++; $display("FAIL bpsk_strobe c=%0d: got %b want 1", c, b_stb); end
            end
            if (c == 48) begin
                vec++; if (b_und !== 1'b1) begin errs++; $display("FAIL bpsk_underrun: got %b want 1", b_und); end
                vec++; if (b_stb !== 1'b0) begin errs++; $display("FAIL bpsk_no_strobe: got %b want 0", b_stb); end
            end
            if (c >= 18 && c <= 22) begin
                vec++; if (b_sin !== rom64[c-18]) begin errs++; $display("FAIL bpsk_sym1 c=%0d: got %0d want %0d", c, b_sin, rom64[c-18]); end
            end
            if (c >= 34 && c <= 38) begin
                vec++; if (b_sin !== rom64[8+c-34]) begin errs++; $display("FAIL bpsk_sym0 c=%0d: got %0d want %0d", c, b_sin, rom64[8+c-34]); end
            end
            en = 1'b1; feed(); @(negedge clk);
        end
    endtask

    task automatic test_qpsk();
        int s;
        int r;
        start();
        qq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 72; c++) begin
            s = c / 16 - 1;
            r = c % 16;
            if (s >= 0 && s < 4) begin
                if (r == 0) begin
                    vec++; if (q_stb !== 1'b1) begin errs++; $display("FAIL qpsk_strobe s=%0d: got %b want 1", s, q_stb); end
                end
                if (r == 2) begin
                    vec++; if (q_sin !== q_e0[s]) begin errs++; $display("FAIL qpsk_first s=%0d: got %0d want %0d", s, q_sin, q_e0[s]); end
                end
                if (r == 3) begin
                    vec++; if (q_sin !== q_e1[s]) begin errs++; $display("FAIL qpsk_second s=%0d: got %0d want %0d", s, q_sin, q_e1[s]); end
                end
            end
            en = 1'b1; feed(); @(negedge clk);
        end
    endtask

    task automatic test_underrun();
        int us = 0;
        int ss = 0;
        start();
        for (int c = 0; c < 52; c++) begin
            if (b_und) us++;
            if (b_stb) ss++;
            if (c == 16) begin
                vec++; if (b_und !== 1'b1) begin errs++; $display("FAIL underrun_first: got %b want 1", b_und); end
            end
            if (c == 18 || c == 19) begin
                vec++; if (b_sin !== rom64[c-18+UND_OFF]) begin errs++; $display("FAIL underrun_phase c=%0d: got %0d want %0d", c, b_sin, rom64[c-18+UND_OFF]); end
            end
            en = 1'b1; feed(); @(negedge clk);
        end
        vec++; if (us != 3) begin errs++; $display("FAIL underrun_count: got %0d want 3", us); end
        vec++; if (ss != 0) begin errs++; $display("FAIL underrun_strobes: got %0d want 0", ss); end
    endtask

    task automatic test_en_pause();
        bit         en_h [48];
        int         e_h [48];
        int         e = 0;
        logic [9:0] want = 10'd512;
        logic       wv;
        start();
        for (int c = 0; c < 41; c++) begin
            wv = 1'b0;
            if (c >= 2) begin
                wv = en_h[c-2];
                if (en_h[c-2]) want = rom64[(e_h[c-2] + UND_OFF) % 16];
            end
            vec++; if (b_vld !== wv) begin errs++; $display("FAIL en_valid c=%0d: got %b want %b", c, b_vld, wv); end
            vec++; if (b_sin !== want) begin errs++; $display("FAIL en_sample c=%0d: got %0d want %0d", c, b_sin, want); end
            if (c == 16 || c == 23) begin
                vec++; if (b_und !== (c == 23)) begin errs++; $display("FAIL en_boundary c=%0d: underrun=%b want %b", c, b_und, c == 23); end
            end
            en = !(c >= 5 && c <= 11);
            en_h[c] = en;
            e_h[c] = e;
            if (en) e++;
            feed(); @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bit         bits[$];
        int         strobes = 0;
        int         unds = 0;
        int         rdy_low = 0;
        int         chk_at = -1;
        int         ph = 0;
        int         sym;
        int         p;
        logic [9:0] want = '0;
        start();
        for (int i = 0; i < 260; i++) bits.push_back($urandom_range(0, 1) != 0);
        qq = bits;
        for (int c = 0; c < 1610; c++) begin
            if (c == chk_at) begin
                vec++; if (q_sin !== want) begin errs++; $display("FAIL bp_symbol c=%0d: got %0d want %0d", c, q_sin, want); end
            end
            if (!ifq.bit_ready) rdy_low++;
            if (q_und) unds++;
            if (q_stb) begin
                sym = 2 * int'(bits[2*strobes]) + int'(bits[2*strobes+1]);
                p = (sym + 2) % 4;
                ph = (ph + p) % 4;
                want = rom64[1 + 4 * (DIFF != 0 ? ph : p)];
                chk_at = c + 3;
                strobes++;
            end
            en = 1'b1; feed(); @(negedge clk);
        end
        vec++; if (strobes != 100) begin errs++; $display("FAIL bp_strobes: got %0d want 100", strobes); end
        vec++; if (unds != 0) begin errs++; $display("FAIL bp_underruns: got %0d want 0", unds); end
        vec++; if (260 - qq.size() != 202) begin errs++; $display("FAIL bp_accepted: got %0d want 202", 260 - qq.size()); end
        vec++; if (rdy_low == 0) begin errs++; $display("FAIL bp_ready_drop: ready-low cycles %0d want >0", rdy_low); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_bpsk();
        test_qpsk();
        test_underrun();
        test_en_pause();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
